// File: rtl/regfile_scoreboard.sv
// Integer register file: 1 write / 2 read ports, optional bypass and zero register, per-register busy scoreboard.
// Latency: writes and reservations land 1 cycle after the edge; reads are combinational (same cycle with bypass).
// Backpressure: none; the hazard unit stalls on busy1/busy2, and wr_unres flags a writeback with no reservation.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int DEPTH   = 1 << ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we3,
    input  logic [ADDR_W-1:0]       wa3,
    input  logic [DATA_W-1:0]       wd3,
    input  logic [ADDR_W-1:0]       ra1,
    input  logic [ADDR_W-1:0]       ra2,
    output logic [DATA_W-1:0]       rd1,
    output logic [DATA_W-1:0]       rd2,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_addr,
    output logic                    busy1,
    output logic                    busy2,
    output logic                    wr_unres,
    output logic [DATA_W*DEPTH-1:0] out
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr_ok;
    logic              rsv_ok;

    // Register 0 swallows writes and reservations when it is hard-wired to zero.
    assign wr_ok  = we3    && !(ZERO_REG && (wa3 == '0));
    assign rsv_ok = rsv_en && !(ZERO_REG && (rsv_addr == '0));

    // Clear first, then set: a new producer supersedes the one writing back.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[wa3] = 1'b0;
        end
        if (rsv_ok) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy     <= '0;
            wr_unres <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[wa3] <= wd3;
                if (!busy[wa3]) begin
                    wr_unres <= 1'b1;
                end
            end
            busy <= busy_nxt;
        end
    end

    // Read port 1
    always_comb begin
        rd1   = mem[ra1];
        busy1 = busy[ra1];
        if (ZERO_REG && (ra1 == '0)) begin
            rd1   = '0;
            busy1 = 1'b0;
        end else if (BYPASS && wr_ok && (wa3 == ra1)) begin
            rd1 = wd3;
            if (!(rsv_ok && (rsv_addr == ra1))) begin
                busy1 = 1'b0;
            end
        end
    end

    // Read port 2
    always_comb begin
        rd2   = mem[ra2];
        busy2 = busy[ra2];
        if (ZERO_REG && (ra2 == '0)) begin
            rd2   = '0;
            busy2 = 1'b0;
        end else if (BYPASS && wr_ok && (wa3 == ra2)) begin
            rd2 = wd3;
            if (!(rsv_ok && (rsv_addr == ra2))) begin
                busy2 = 1'b0;
            end
        end
    end

    // Debug view always reflects the registered array, never the bypass.
    for (genvar g = 0; g < DEPTH; g++) begin : g_out
        assign out[g*DATA_W +: DATA_W] = mem[g];
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: default instance, a no-bypass twin on the same stimulus, and a small ZERO_REG=0 instance.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, we3, rsv_en;
    logic [4:0]  wa3, ra1, ra2, rsv_addr;
    logic [31:0] wd3;

    logic [31:0]   a_rd1, a_rd2, b_rd1, b_rd2;
    logic          a_busy1, a_busy2, b_busy1, b_busy2, a_unres, b_unres;
    logic [1023:0] a_out, b_out;

    logic        c_we, c_rsv_en, c_busy1, c_busy2, c_unres;
    logic [2:0]  c_wa, c_ra1, c_ra2, c_rsv_addr;
    logic [15:0] c_wd, c_rd1, c_rd2;
    logic [127:0] c_out;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_scoreboard u_a (
        .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(a_rd1), .rd2(a_rd2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(a_busy1), .busy2(a_busy2),
        .wr_unres(a_unres), .out(a_out)
    );

    regfile_scoreboard #(.BYPASS(1'b0)) u_b (
        .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(b_rd1), .rd2(b_rd2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(b_busy1), .busy2(b_busy2),
        .wr_unres(b_unres), .out(b_out)
    );

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) u_c (
        .clk(clk), .rst(rst), .we3(c_we), .wa3(c_wa), .wd3(c_wd),
        .ra1(c_ra1), .ra2(c_ra2), .rd1(c_rd1), .rd2(c_rd2),
        .rsv_en(c_rsv_en), .rsv_addr(c_rsv_addr), .busy1(c_busy1), .busy2(c_busy2),
        .wr_unres(c_unres), .out(c_out)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we3    = 1'b0;
        rsv_en = 1'b0;
    endtask

    // Sweep every address on both 32-register instances and OR their busy bits.
    task automatic busy_sweep(input string tag, input logic exp);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            #0.1;
            acc = acc | a_busy1 | b_busy1;
        end
        chk(tag, acc, exp);
    endtask

    initial begin
        c_we = 1'b0; c_rsv_en = 1'b0; c_wa = '0; c_wd = '0;
        c_ra1 = '0; c_ra2 = '0; c_rsv_addr = '0;
        ra1 = '0; ra2 = '0; rsv_addr = 5'd0; rsv_en = 1'b0;

        // Reset with a write pending: the write must be ignored.
        rst = 1'b0; we3 = 1'b1; wa3 = 5'd3; wd3 = 32'hFFFF_FFFF;
        tick();
        rst = 1'b1;
        idle();
        chk("rst_out_a", 64'(|a_out), 64'd0);
        chk("rst_out_b", 64'(|b_out), 64'd0);
        chk("rst_unres", {a_unres, b_unres}, 2'b00);
        busy_sweep("rst_busy", 1'b0);

        // Zero register ignores writes and never bypasses.
        we3 = 1'b1; wa3 = 5'd0; wd3 = 32'h1234; ra1 = 5'd0;
        #1;
        chk("zero_rd_bypass", a_rd1, 32'h0);
        tick();
        idle();
        chk("zero_out", a_out[31:0], 32'h0);
        chk("zero_unres", {a_unres, b_unres}, 2'b00);

        // Reserve 5, then write it back with a same-cycle read.
        rsv_en = 1'b1; rsv_addr = 5'd5;
        tick();
        idle();
        we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hCAFE_0001; ra1 = 5'd5; ra2 = 5'd5;
        #1;
        chk("byp_rd1", a_rd1, 32'hCAFE_0001);
        chk("byp_busy1", a_busy1, 1'b0);
        chk("nobyp_rd1", b_rd1, 32'h0);
        chk("nobyp_busy1", b_busy1, 1'b1);
        tick();
        idle();
        chk("wb_out_a", a_out[5*32 +: 32], 32'hCAFE_0001);
        chk("wb_out_b", b_out[5*32 +: 32], 32'hCAFE_0001);
        chk("wb_rd_both", {a_rd1, a_rd2}, {32'hCAFE_0001, 32'hCAFE_0001});
        chk("wb_nobyp_after", {b_rd1, b_busy1}, {32'hCAFE_0001, 1'b0});
        chk("wb_unres", {a_unres, b_unres}, 2'b00);

        // Reserve and write back 7 in the same cycle: reservation wins, data lands.
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        we3 = 1'b1; wa3 = 5'd7; wd3 = 32'h55; ra2 = 5'd7;
        #1;
        chk("conf_busy2_comb", a_busy2, 1'b1);
        tick();
        idle();
        chk("conf_reg7", a_out[7*32 +: 32], 32'h55);
        chk("conf_busy2", {a_busy2, b_busy2}, 2'b11);
        chk("conf_unres", {a_unres, b_unres}, 2'b00);

        // Different addresses in one cycle: clear 7 and reserve 10.
        we3 = 1'b1; wa3 = 5'd7; wd3 = 32'h66; rsv_en = 1'b1; rsv_addr = 5'd10;
        ra1 = 5'd10;
        tick();
        idle();
        chk("split_busy7", {a_busy2, b_busy2}, 2'b00);
        chk("split_busy10", {a_busy1, b_busy1}, 2'b11);

        // Write to non-busy 9 raises the sticky flag.
        we3 = 1'b1; wa3 = 5'd9; wd3 = 32'hA;
        tick();
        idle();
        chk("unres_set", {a_unres, b_unres}, 2'b11);
        we3 = 1'b1; wa3 = 5'd10; wd3 = 32'hB;
        tick();
        idle();
        chk("unres_sticky", {a_unres, b_unres}, 2'b11);
        chk("legal_clear10", a_busy1, 1'b0);

        // Build up state, then reset mid-operation with a write and reservation pending.
        rsv_en = 1'b1; rsv_addr = 5'd2;
        tick();
        rsv_addr = 5'd4; we3 = 1'b1; wa3 = 5'd4; wd3 = 32'h77;
        tick();
        idle();
        ra1 = 5'd4; ra2 = 5'd2;
        #1;
        chk("pre_rst_reg4", a_out[4*32 +: 32], 32'h77);
        chk("pre_rst_busy", {a_busy1, a_busy2}, 2'b11);
        rst = 1'b0; we3 = 1'b1; wa3 = 5'd2; wd3 = 32'h99; rsv_en = 1'b1; rsv_addr = 5'd6;
        tick();
        rst = 1'b1;
        idle();
        chk("mid_rst_out_a", 64'(|a_out), 64'd0);
        chk("mid_rst_out_b", 64'(|b_out), 64'd0);
        chk("mid_rst_unres", {a_unres, b_unres}, 2'b00);
        busy_sweep("mid_rst_busy", 1'b0);

        // Small instance: register 0 is ordinary.
        c_we = 1'b1; c_wa = 3'd0; c_wd = 16'hBEEF; c_rsv_en = 1'b1; c_rsv_addr = 3'd0;
        c_ra1 = 3'd0;
        #1;
        chk("c_byp_rd1", c_rd1, 16'hBEEF);
        chk("c_byp_busy1", c_busy1, 1'b0);
        tick();
        c_we = 1'b0; c_rsv_en = 1'b0;
        #1;
        chk("c_rd1", c_rd1, 16'hBEEF);
        chk("c_busy1", c_busy1, 1'b1);
        chk("c_out0", c_out[15:0], 16'hBEEF);
        chk("c_unres", c_unres, 1'b1);
        chk("c_out_width", 64'($bits(u_c.out)), 64'd128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
